// File: rtl/vpu_alu_imul_pipe_pkg.sv
// Shared types and helpers for the VPU ALU pipelined integer multiplier.
// Optional saturation support is compiled in with VPU_IMUL_SAT_EN.
package vpu_alu_imul_pipe_pkg;

   localparam int unsigned IMUL_LATENCY = 3;

   typedef struct packed {
      logic sgn;
      logic high;
      logic three_op;
   } imul_mode_t;

   typedef struct packed {
      logic       valid;
      imul_mode_t mode;
   } imul_stage_t;

`ifdef VPU_IMUL_SAT_EN
   // Clamp a sign/zero-extended product to the w-bit range; returns {clipped, value}.
   function automatic logic [32:0] sat_w(input logic [63:0] p, input int unsigned w,
                                         input logic sgn);
      logic [63:0] top_v;
      logic [63:0] lim_v;
      logic        fits_v;
      if (sgn) begin
         top_v  = $signed(p) >>> (w - 32'd1);
         fits_v = (top_v == 64'd0) || (top_v == {64{1'b1}});
         lim_v  = p[63] ? (64'd1 << (w - 32'd1)) : ((64'd1 << (w - 32'd1)) - 64'd1);
      end else begin
         top_v  = p >> w;
         fits_v = (top_v == 64'd0);
         lim_v  = (64'd1 << w) - 64'd1;
      end
      return {~fits_v, fits_v ? p[31:0] : lim_v[31:0]};
   endfunction
`endif

endpackage

// File: rtl/vpu_alu_imul_pipe_lane.sv
// One lane of the multiplier: S1 holds A*B, S2 holds the final 2W product.
// With VPU_IMUL_SAT_EN each low-half stage clamps and reports a sticky clip flag.
module vpu_alu_imul_pipe_lane
   import vpu_alu_imul_pipe_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s1_en_i,
   input  logic           s2_en_i,
   input  logic           sgn0_i,
   input  logic           sgn1_i,
   input  logic           three1_i,
`ifdef VPU_IMUL_SAT_EN
   input  logic           sat0_i,
   input  logic           sat1_i,
   output logic           sat_o,
`endif
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  logic [W-1:0]   c_i,
   output logic [2*W-1:0] f_o
);

   function automatic logic [2*W-1:0] ext(input logic [W-1:0] x, input logic sgn);
      return sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
   endfunction

   logic [2*W-1:0] prod1_s, prod2_s, p1_d, f_d, p1_q, f_q;
   logic [W-1:0]   c_q;

`ifdef VPU_IMUL_SAT_EN
   function automatic logic [63:0] ext64(input logic [2*W-1:0] x, input logic sgn);
      logic signed [63:0] s_v;
      logic [63:0]        u_v;
      s_v = 64'($signed(x));
      u_v = 64'(x);
      return sgn ? s_v : u_v;
   endfunction

   logic [32:0] s1r_s, s2r_s;
   logic        sat1_d, sat2_d, sat1_q, sat2_q;

   // Per-stage products, clamped to W bits when the low half is requested
   always_comb begin
      prod1_s = ext(a_i, sgn0_i) * ext(b_i, sgn0_i);
      prod2_s = ext(p1_q[W-1:0], sgn1_i) * ext(c_q, sgn1_i);
      s1r_s   = sat_w(ext64(prod1_s, sgn0_i), W, sgn0_i);
      s2r_s   = sat_w(ext64(prod2_s, sgn1_i), W, sgn1_i);
      p1_d    = sat0_i ? ext(s1r_s[W-1:0], sgn0_i) : prod1_s;
      sat1_d  = sat0_i & s1r_s[32];
      f_d     = three1_i ? (sat1_i ? ext(s2r_s[W-1:0], sgn1_i) : prod2_s) : p1_q;
      sat2_d  = sat1_q | (sat1_i & three1_i & s2r_s[32]);
   end
`else
   // Per-stage products at full 2W width
   always_comb begin
      prod1_s = ext(a_i, sgn0_i) * ext(b_i, sgn0_i);
      prod2_s = ext(p1_q[W-1:0], sgn1_i) * ext(c_q, sgn1_i);
      p1_d    = prod1_s;
      f_d     = three1_i ? prod2_s : p1_q;
   end
`endif

   // Lane data registers, advanced by the parent's stall control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_q <= '0;
         c_q  <= '0;
         f_q  <= '0;
`ifdef VPU_IMUL_SAT_EN
         sat1_q <= 1'b0;
         sat2_q <= 1'b0;
`endif
      end else begin
         if (s1_en_i) begin
            p1_q <= p1_d;
            c_q  <= c_i;
`ifdef VPU_IMUL_SAT_EN
            sat1_q <= sat1_d;
`endif
         end
         if (s2_en_i) begin
            f_q <= f_d;
`ifdef VPU_IMUL_SAT_EN
            sat2_q <= sat2_d;
`endif
         end
      end
   end

   assign f_o = f_q;
`ifdef VPU_IMUL_SAT_EN
   assign sat_o = sat2_q;
`endif

endmodule

// File: rtl/vpu_alu_imul_pipe.sv
// Pipelined multi-lane integer multiplier (S0 -> S1 -> S2 -> output) with valid/ready
// back-pressure. Define VPU_IMUL_SAT_EN to add low-half saturation and the sat_o port.
module vpu_alu_imul_pipe
   import vpu_alu_imul_pipe_pkg::*;
#(
   parameter int unsigned LANE_CNT        = 4,
   parameter int unsigned ELEM_WIDTH      = 16,
   parameter int unsigned TAG_WIDTH       = 4,
   parameter int unsigned SRAM_R_PORT_CNT = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   output logic                           ready_o,
   input  logic [TAG_WIDTH-1:0]           tag_i,
   input  logic                           signed_i,
   input  logic                           high_i,
   input  logic [LANE_CNT*ELEM_WIDTH-1:0] op_0,
   input  logic [LANE_CNT*ELEM_WIDTH-1:0] op_1,
   input  logic [LANE_CNT*ELEM_WIDTH-1:0] op_2,
   input  logic [SRAM_R_PORT_CNT-1:0]     op_valid,
`ifdef VPU_IMUL_SAT_EN
   output logic [LANE_CNT-1:0]            sat_o,
`endif
   output logic [LANE_CNT*ELEM_WIDTH-1:0] result_o,
   output logic [TAG_WIDTH-1:0]           tag_o,
   output logic                           done_o,
   input  logic                           dst_ready_i
);

   localparam int unsigned W  = ELEM_WIDTH;
   localparam int unsigned VW = LANE_CNT * ELEM_WIDTH;

   imul_stage_t          s0_q, s1_q;
   logic                 s2_valid_q, s2_high_q, done_q;
   logic [TAG_WIDTH-1:0] s0_tag_q, s1_tag_q, s2_tag_q, tag_q;
   logic [VW-1:0]        a_q, b_q, c_q, result_q, res_s;
   logic                 out_en_s, s2_en_s, s1_en_s, s0_en_s;
   logic [2*W-1:0]       f_s [LANE_CNT];
   logic                 unused_opv_s;

   // Only the top op_valid bit selects the 3-operand product
   assign unused_opv_s = ^op_valid[SRAM_R_PORT_CNT-2:0];

   assign out_en_s = !done_q || dst_ready_i;
   assign s2_en_s  = !s2_valid_q || out_en_s;
   assign s1_en_s  = !s1_q.valid || s2_en_s;
   assign s0_en_s  = !s0_q.valid || s1_en_s;
   assign ready_o  = s0_en_s;

   // Stage control and operand capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q       <= '0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_high_q  <= 1'b0;
         s0_tag_q   <= '0;
         s1_tag_q   <= '0;
         s2_tag_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
      end else begin
         if (s0_en_s) begin
            s0_q.valid <= start_i;
            if (start_i) begin
               s0_q.mode.sgn      <= signed_i;
               s0_q.mode.high     <= high_i;
               s0_q.mode.three_op <= op_valid[SRAM_R_PORT_CNT-1];
               s0_tag_q           <= tag_i;
               a_q                <= op_0;
               b_q                <= op_1;
               c_q                <= op_2;
            end
         end
         if (s1_en_s) begin
            s1_q     <= s0_q;
            s1_tag_q <= s0_tag_q;
         end
         if (s2_en_s) begin
            s2_valid_q <= s1_q.valid;
            s2_high_q  <= s1_q.mode.high;
            s2_tag_q   <= s1_tag_q;
         end
      end
   end

`ifdef VPU_IMUL_SAT_EN
   logic [LANE_CNT-1:0] lane_sat_s, sat_q;
`endif

   for (genvar i = 0; i < LANE_CNT; i++) begin : g_lane
      vpu_alu_imul_pipe_lane #(.W(W)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .s1_en_i  (s1_en_s),
         .s2_en_i  (s2_en_s),
         .sgn0_i   (s0_q.mode.sgn),
         .sgn1_i   (s1_q.mode.sgn),
         .three1_i (s1_q.mode.three_op),
`ifdef VPU_IMUL_SAT_EN
         .sat0_i   (!s0_q.mode.high),
         .sat1_i   (!s1_q.mode.high),
         .sat_o    (lane_sat_s[i]),
`endif
         .a_i      (a_q[i*W +: W]),
         .b_i      (b_q[i*W +: W]),
         .c_i      (c_q[i*W +: W]),
         .f_o      (f_s[i])
      );
      assign res_s[i*W +: W] = s2_high_q ? f_s[i][2*W-1:W] : f_s[i][W-1:0];
   end

   // Output register: holds until VPU_DST_PORT takes it, reloads on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q   <= 1'b0;
         result_q <= '0;
         tag_q    <= '0;
`ifdef VPU_IMUL_SAT_EN
         sat_q    <= '0;
`endif
      end else if (out_en_s) begin
         done_q <= s2_valid_q;
         if (s2_valid_q) begin
            result_q <= res_s;
            tag_q    <= s2_tag_q;
`ifdef VPU_IMUL_SAT_EN
            sat_q    <= lane_sat_s;
`endif
         end
      end
   end

   assign done_o   = done_q;
   assign result_o = result_q;
   assign tag_o    = tag_q;
`ifdef VPU_IMUL_SAT_EN
   assign sat_o    = sat_q;
`endif

endmodule

// File: tb/tb_vpu_alu_imul_pipe.sv
// Randomized self-checking bench for vpu_alu_imul_pipe against an integer-arithmetic model.
// Saturation checks are included when VPU_IMUL_SAT_EN is defined.
module tb_vpu_alu_imul_pipe;
   import vpu_alu_imul_pipe_pkg::*;

   localparam int LANES = 4;
   localparam int W     = 16;
   localparam int TW    = 4;
   localparam int NP    = 3;
   localparam int VW    = LANES * W;

   logic           clk, rst_n, start_i, ready_o, signed_i, high_i, done_o, dst_ready_i;
   logic [TW-1:0]  tag_i, tag_o;
   logic [VW-1:0]  op_0, op_1, op_2, result_o;
   logic [NP-1:0]  op_valid;
`ifdef VPU_IMUL_SAT_EN
   logic [LANES-1:0] sat_o;
`endif

   vpu_alu_imul_pipe #(.LANE_CNT(LANES), .ELEM_WIDTH(W), .TAG_WIDTH(TW), .SRAM_R_PORT_CNT(NP)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_o(ready_o), .tag_i(tag_i),
      .signed_i(signed_i), .high_i(high_i), .op_0(op_0), .op_1(op_1), .op_2(op_2),
      .op_valid(op_valid),
`ifdef VPU_IMUL_SAT_EN
      .sat_o(sat_o),
`endif
      .result_o(result_o), .tag_o(tag_o), .done_o(done_o), .dst_ready_i(dst_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [VW-1:0]    res;
      logic [TW-1:0]    tag;
      logic [LANES-1:0] sat;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic longint sval(input logic [W-1:0] x, input bit sgn);
      if (sgn) return longint'($signed(x));
      return longint'(x);
   endfunction

   function automatic longint clamp(input longint v, input bit sgn, output bit hit);
      longint lo, hi;
      lo  = sgn ? -(longint'(1) <<< (W - 1)) : 0;
      hi  = sgn ? (longint'(1) <<< (W - 1)) - 1 : (longint'(1) <<< W) - 1;
      hit = (v < lo) || (v > hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference: exact integer products, then truncate/clamp per the mode rules
   task automatic model(input logic [VW-1:0] a, b, c, input bit sgn, high, three,
                        output logic [VW-1:0] res, output logic [LANES-1:0] sat);
      for (int l = 0; l < LANES; l++) begin
         longint      p, p1v, f;
         logic [63:0] fb;
         bit          h1, h2, satmode;
         h1 = 1'b0;
         h2 = 1'b0;
`ifdef VPU_IMUL_SAT_EN
         satmode = !high;
`else
         satmode = 1'b0;
`endif
         p  = sval(a[l*W +: W], sgn) * sval(b[l*W +: W], sgn);
         fb = p;
         if (satmode) p1v = clamp(p, sgn, h1);
         else         p1v = sval(fb[W-1:0], sgn);
         if (three) begin
            f = p1v * sval(c[l*W +: W], sgn);
            if (satmode) f = clamp(f, sgn, h2);
         end else begin
            f = satmode ? p1v : p;
         end
         fb = f;
         res[l*W +: W] = high ? fb[2*W-1 -: W] : fb[W-1:0];
         sat[l] = h1 | h2;
      end
   endtask

   // One clock of stimulus; scoreboard bookkeeping happens before the rising edge
   task automatic step(input bit st, input bit drdy, input logic [VW-1:0] a, b, c,
                       input bit sgn, high, three, input logic [TW-1:0] tg);
      exp_t e;
      @(negedge clk);
      start_i = st; dst_ready_i = drdy; op_0 = a; op_1 = b; op_2 = c;
      signed_i = sgn; high_i = high; tag_i = tg;
      op_valid = NP'($urandom);
      op_valid[NP-1] = three;
      #1;
      if (done_o) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_done", 64'(done_o), 64'd0);
         end else begin
            e = sb_q[0];
            check_eq("result", result_o, e.res);
            check_eq("tag", 64'(tag_o), 64'(e.tag));
`ifdef VPU_IMUL_SAT_EN
            check_eq("sat", 64'(sat_o), 64'(e.sat));
`endif
            if (drdy) void'(sb_q.pop_front());
         end
      end
      if (st && ready_o) begin
         model(a, b, c, sgn, high, three, e.res, e.sat);
         e.tag = tg;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input bit drdy);
      step(1'b0, drdy, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   // Lone op into an empty pipe: check latency and a known per-lane result
   task automatic single(input string name, input logic [W-1:0] a, b, c,
                         input bit sgn, high, three, input logic [W-1:0] exp_lane);
      int n;
      step(1'b1, 1'b1, {LANES{a}}, {LANES{b}}, {LANES{c}}, sgn, high, three, 4'h0);
      n = 0;
      do begin
         idle(1'b1);
         n++;
      end while (!done_o && n < 20);
      check_eq({name, "_done"}, 64'(done_o), 64'd1);
      // accepted on edge N; done first seen on the falling edge after edge N+3
      check_eq({name, "_lat"}, 64'(n), 64'(IMUL_LATENCY + 1));
      check_eq(name, result_o, {LANES{exp_lane}});
   endtask

   function automatic logic [VW-1:0] rand_op();
      logic [VW-1:0] v;
      for (int l = 0; l < LANES; l++) begin
         case ($urandom_range(0, 3))
            0:       v[l*W +: W] = W'($urandom_range(0, 15));
            1:       v[l*W +: W] = {1'b1, {(W-1){1'b0}}} | W'($urandom_range(0, 3));
            2:       v[l*W +: W] = {W{1'b1}} - W'($urandom_range(0, 3));
            default: v[l*W +: W] = W'($urandom);
         endcase
      end
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, required finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      logic [VW-1:0] a4, b4, c4;
      int n;
      rst_n = 1'b0; start_i = 1'b0; dst_ready_i = 1'b0; tag_i = '0; signed_i = 1'b0;
      high_i = 1'b0; op_0 = '0; op_1 = '0; op_2 = '0; op_valid = '0;
      #12;
      check_eq("rst_done", 64'(done_o), 64'd0);
      check_eq("rst_ready", 64'(ready_o), 64'd1);
      check_eq("rst_result", result_o, 64'd0);
      check_eq("rst_tag", 64'(tag_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      single("u_lo_2op", 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h000F);
      single("s_hi_2op", 16'hFFFF, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF);
      single("u_hi_2op", 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001);
      single("lo_3op", 16'h0002, 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h002A);
      single("wrap_3op", 16'h0100, 16'h0100, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef VPU_IMUL_SAT_EN
      single("sat_clip", 16'h4000, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h7FFF);
      check_eq("sat_clip_flag", 64'(sat_o), 64'({LANES{1'b1}}));
      single("sat_none", 16'h0002, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0006);
      check_eq("sat_none_flag", 64'(sat_o), 64'd0);
`endif
      idle(1'b1);

      // Back-pressure: five issues, only four fit while the sink stalls
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b0, rand_op(), rand_op(), rand_op(), k[0], 1'b0, k[1], TW'(k));
      a4 = rand_op(); b4 = rand_op(); c4 = rand_op();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, a4, b4, c4, 1'b1, 1'b1, 1'b0, 4'd4);
         check_eq("bp_ready", 64'(ready_o), 64'd0);
         check_eq("bp_tag_hold", 64'(tag_o), 64'd0);
      end
      check_eq("bp_accepted", 64'(sb_q.size()), 64'd4);
      step(1'b1, 1'b1, a4, b4, c4, 1'b1, 1'b1, 1'b0, 4'd4);
      check_eq("bp_release_ready", 64'(ready_o), 64'd1);
      check_eq("bp_order_tag0", 64'(tag_o), 64'd0);
      for (int k = 1; k < 5; k++) begin
         idle(1'b1);
         check_eq("bp_stream_done", 64'(done_o), 64'd1);
         check_eq("bp_order_tag", 64'(tag_o), 64'(k));
      end
      idle(1'b1);
      check_eq("bp_drained", 64'(sb_q.size()), 64'd0);

      // Reset with ops in flight
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b1, rand_op(), rand_op(), rand_op(), 1'b0, 1'b0, 1'b0, TW'(k + 8));
      idle(1'b0);
      idle(1'b0);
      check_eq("pre_rst_done", 64'(done_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_done", 64'(done_o), 64'd0);
      check_eq("midrst_ready", 64'(ready_o), 64'd1);
      check_eq("midrst_result", result_o, 64'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         idle(1'b1);
         check_eq("no_stale_done", 64'(done_o), 64'd0);
      end

      // Random traffic with random back-pressure
      for (int k = 0; k < 600; k++)
         step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70, rand_op(), rand_op(),
              rand_op(), 1'($urandom), 1'($urandom), 1'($urandom), TW'($urandom));
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         idle(1'b1);
         n++;
      end
      check_eq("final_drain", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vpu_alu_imul_pipe.md
Name: vpu_alu_imul_pipe

Overview:
Parametrised, fully pipelined integer multiplier for the VPU ALU. It processes LANE_CNT lanes of ELEM_WIDTH elements in parallel and supports 2- and 3-operand products, signed/unsigned operation, and low/high-half result selection. A valid/ready handshake with back-pressure from VPU_DST_PORT replaces the fixed delay counter of the previous generation. It sits between the SRC_PORT operand mux and VPU_DST_PORT, and VPU_CONTROLLER issues into it.

Parameters:
LANE_CNT, 4, number of parallel element lanes
ELEM_WIDTH, 16, bits per element (8, 16 or 32)
TAG_WIDTH, 4, controller tag carried alongside each operation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  issue valid from VPU_CONTROLLER
ready_o  out  1  block can accept an issue this cycle
tag_i  in  TAG_WIDTH  opaque tag returned with the result
signed_i  in  1  1 = two's-complement operands, 0 = unsigned
high_i  in  1  1 = return high half of the final product, 0 = low half
op_0  in  LANE_CNT*ELEM_WIDTH  operand A, lane i at bits [i*ELEM_WIDTH +: ELEM_WIDTH]
op_1  in  LANE_CNT*ELEM_WIDTH  operand B
op_2  in  LANE_CNT*ELEM_WIDTH  operand C
op_valid  in  SRAM_R_PORT_CNT  bit SRAM_R_PORT_CNT-1 set = 3-operand product A*B*C
result_o  out  LANE_CNT*ELEM_WIDTH  per-lane result
tag_o  out  TAG_WIDTH  tag of the result
done_o  out  1  result valid
dst_ready_i  in  1  VPU_DST_PORT accepts the result

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: done_o=0, result_o=0, tag_o=0, ready_o=1, all stage valids cleared.
- Accept: an issue is accepted on a rising edge with start_i && ready_o. Operands, tag, signed_i, high_i and the 3-operand flag are captured into S0.
- Pipeline S0 -> S1 -> S2:
  - S0 registers the inputs.
  - S1 computes P1 = A*B at full 2W width per lane and keeps the low W bits as p1.
  - S2 computes the final product:
    - 3-operand: F = p1*C at 2W, signedness per signed_i.
    - 2-operand: F = the S1 2W product passed through.
  - Output register: result = high_i ? F[2W-1:W] : F[W-1:0].
- Latency: an accepted issue at cycle N gives done_o=1 at cycle N+3 when there is no back-pressure. Throughput is 1 issue per cycle.
- Handshake:
  - done_o stays high, and result_o and tag_o hold stable, until dst_ready_i=1. The output is consumed on an edge with done_o && dst_ready_i.
  - Stall rule: a stage advances when the next stage is empty or advancing.
  - ready_o = !S0_valid || S0_advances. This is a combinational path from dst_ready_i, at most 4 deep.
- Simultaneous events:
  - Consume and new completion in the same cycle: the output register reloads, and done_o stays 1.
  - Issue into a full pipe with dst_ready_i=1: accepted, and no bubble is inserted.
- Full pipe: 4 ops in flight with dst_ready_i=0 gives ready_o=0. Any start_i seen then is ignored, and the controller must hold it.
- Arithmetic:
  - Signed mode sign-extends each operand to 2W before multiplying.
  - Unsigned mode zero-extends.
  - No wrap detection in the base build.
- Reset mid-operation: all in-flight ops are discarded, and there is no done pulse for them.

Optional Feature:
Macro VPU_IMUL_SAT_EN.
- Defined:
  - When high_i=0, each multiply stage saturates to the W-bit range instead of truncating. Ranges: signed [-2^(W-1), 2^(W-1)-1], unsigned [0, 2^W-1].
  - p1 is saturated before the second multiply.
  - Adds output sat_o [LANE_CNT-1:0], a per-lane sticky flag for the op that is set if either stage clipped. It is valid with done_o and resets to 0.
- Undefined: pure truncation, and the sat_o port is absent.

Decomposition:
- VPU_PKG gains:
  - IMUL_LATENCY=3.
  - typedef imul_mode_t {signed, high, three_op}.
  - typedef imul_stage_t {valid, tag, mode, data}.
  - Function sat_w() (only under VPU_IMUL_SAT_EN).
- Sub-module vpu_imul_lane: one lane's S1/S2 arithmetic, generated LANE_CNT times. Control and valids stay in the parent.

Test Plan:
1. Unsigned low 2-op, W=16: A=0x0003, B=0x0005 in all lanes, dst_ready_i=1 -> done_o at N+3, result=0x000F per lane.
2. Signed high 2-op: A=0xFFFF(-1), B=0x0002 -> F=0xFFFFFFFE, result=0xFFFF; the same inputs unsigned -> result=0x0001.
3. 3-op low: op_valid MSB=1, A=2, B=3, C=7 -> result=0x002A. Wrap case A=0x0100, B=0x0100, C=3 -> result=0x0000.
4. Back-pressure: issue 5 back-to-back ops with dst_ready_i=0 -> ready_o falls after 4 accepted, result holds op #1. Release -> results in order with tags 0..4, one per cycle, none lost.
5. rst_n asserted with 3 ops in flight -> done_o=0 immediately, ready_o=1, no stale result after release.
6. (SAT_EN) signed low, A=0x4000, B=0x0004 -> result=0x7FFF, sat_o=all ones; A=2, B=3 -> sat_o=0.
